// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state encoding and sizing helper for the FIFO write arbiter
package fifo_arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin pick: first requester after the last owner, wrapping
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IW      = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      last,
   output logic               any,
   output logic [IW-1:0]      idx
);

   logic [NUM_REQ-1:0] upper;

   always_comb begin
      upper = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         upper[i] = req[i] && (i > int'(last));
      end
   end

   // Lowest set bit above last wins; otherwise wrap to the lowest set bit overall.
   always_comb begin
      any = |req;
      idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) idx = IW'(i);
      end
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (upper[i]) idx = IW'(i);
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the FIFO write port with credit flow control
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 8,
   parameter int MAX_BURST  = 4,
   parameter int CNT_WIDTH  = clog2(MEM_DEPTH + 1)
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          fifo_wr,
   output logic [DATA_WIDTH-1:0]         fifo_din,
   input  logic                          fifo_rd,
   output logic [CNT_WIDTH-1:0]          level,
   output logic [clog2(NUM_REQ)-1:0]     grant_id,
   output logic                          busy
);

   localparam int IW = clog2(NUM_REQ);
   localparam int BW = clog2(MAX_BURST + 1);
   localparam logic [CNT_WIDTH-1:0] FULL      = CNT_WIDTH'(MEM_DEPTH);
   localparam logic [BW-1:0]        LAST_BEAT = BW'(MAX_BURST - 1);
   localparam logic [IW-1:0]        LAST_INIT = IW'(NUM_REQ - 1);

   arb_state_t    state, state_n;
   logic [BW-1:0] beat_cnt, beat_n;
   logic [IW-1:0] last_grant, last_n, owner_n;
   logic [IW-1:0] pick_idx;
   logic          pick_any;
   logic          owner_valid, credit, xfer;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_pick (
      .req  (req_valid),
      .last (last_grant),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   // Credit comes from the registered level only, so a same-cycle pop never frees a slot early.
   assign owner_valid = req_valid[grant_id];
   assign credit      = (level < FULL);
   assign busy        = (state == ST_GRANT);
   assign xfer        = busy && owner_valid && credit;

   always_comb begin
      req_ready = '0;
      if (busy) req_ready[grant_id] = credit;
      fifo_wr  = xfer;
      fifo_din = xfer ? req_data[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
   end

   always_comb begin
      state_n = state;
      owner_n = grant_id;
      beat_n  = beat_cnt;
      last_n  = last_grant;
      case (state)
         ST_IDLE: begin
            if (pick_any) begin
               state_n = ST_GRANT;
               owner_n = pick_idx;
               beat_n  = '0;
            end
         end
         ST_GRANT: begin
            if (!owner_valid) begin
               state_n = ST_IDLE;
               last_n  = grant_id;
            end else if (xfer) begin
               if (beat_cnt == LAST_BEAT) begin
                  state_n = ST_IDLE;
                  last_n  = grant_id;
               end else begin
                  beat_n = beat_cnt + 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= ST_IDLE;
         beat_cnt   <= '0;
         grant_id   <= '0;
         last_grant <= LAST_INIT;
         level      <= '0;
      end else begin
         state      <= state_n;
         beat_cnt   <= beat_n;
         grant_id   <= owner_n;
         last_grant <= last_n;
         // A pop on an empty FIFO is ignored; write plus valid pop leaves level unchanged.
         if (xfer && !(fifo_rd && level != '0)) begin
            level <= level + 1'b1;
         end else if (!xfer && fifo_rd && level != '0) begin
            level <= level - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed and random checks of the arbiter against a transaction model
module tb_fifo_wr_arbiter;
   import fifo_arb_pkg::*;

   localparam int NR    = 4;
   localparam int W     = 32;
   localparam int DEPTH = 8;
   localparam int MB    = 4;
   localparam int IW    = clog2(NR);
   localparam int CW    = clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic [NR-1:0]     req_valid;
   logic [NR*W-1:0]   req_data;
   logic [NR-1:0]     req_ready;
   logic              fifo_wr;
   logic [W-1:0]      fifo_din;
   logic              fifo_rd;
   logic [CW-1:0]     level;
   logic [IW-1:0]     grant_id;
   logic              busy;

   fifo_wr_arbiter #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (W),
      .MEM_DEPTH  (DEPTH),
      .MAX_BURST  (MB)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .fifo_wr   (fifo_wr),
      .fifo_din  (fifo_din),
      .fifo_rd   (fifo_rd),
      .level     (level),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Transaction-level reference state
   int         m_busy, m_owner, m_last, m_beats, m_level;
   int         seq   [NR];
   int         limit [NR];
   logic [W-1:0] base [NR];
   int         grants[$];
   int         wr_count;
   logic       prev_busy;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_busy    = 0;
      m_owner   = 0;
      m_last    = NR - 1;
      m_beats   = 0;
      m_level   = 0;
      prev_busy = 1'b0;
   endtask

   task automatic tick(input logic [NR-1:0] v, input logic rd);
      logic [NR-1:0] vv;
      logic [NR-1:0] e_ready;
      logic          e_wr;
      logic [W-1:0]  e_din;
      int            lvl_old;
      for (int i = 0; i < NR; i++) begin
         vv[i] = v[i] && (seq[i] < limit[i]);
         req_data[i*W +: W] = base[i] + W'(seq[i]);
      end
      req_valid = vv;
      fifo_rd   = rd;
      e_ready = '0;
      e_wr    = 1'b0;
      e_din   = '0;
      if (m_busy != 0) begin
         e_ready[m_owner] = (m_level < DEPTH);
         e_wr = vv[m_owner] && (m_level < DEPTH);
         if (e_wr) e_din = base[m_owner] + W'(seq[m_owner]);
      end
      #3;
      chk("req_ready", 64'(req_ready), 64'(e_ready));
      chk("fifo_wr",   64'(fifo_wr),   64'(e_wr));
      chk("fifo_din",  64'(fifo_din),  64'(e_din));
      chk("level",     64'(level),     64'(m_level));
      chk("busy",      64'(busy),      64'(m_busy != 0));
      chk("grant_id",  64'(grant_id),  64'(m_owner));
      if (busy && !prev_busy) grants.push_back(int'(grant_id));
      prev_busy = busy;
      if (fifo_wr) wr_count++;
      @(posedge clk);
      lvl_old = m_level;
      if (e_wr) seq[m_owner]++;
      if (m_busy == 0) begin
         if (vv != '0) begin
            for (int k = NR; k >= 1; k--) begin
               if (vv[(m_last + k) % NR]) m_owner = (m_last + k) % NR;
            end
            m_busy  = 1;
            m_beats = 0;
         end
      end else if (!vv[m_owner]) begin
         m_busy = 0;
         m_last = m_owner;
      end else if (e_wr) begin
         m_beats++;
         if (m_beats == MB) begin
            m_busy = 0;
            m_last = m_owner;
         end
      end
      if (e_wr) m_level++;
      if (rd && lvl_old > 0) m_level--;
      #1;
   endtask

   initial begin
      req_valid = '0;
      req_data  = '0;
      fifo_rd   = 1'b0;
      for (int i = 0; i < NR; i++) begin
         seq[i]   = 0;
         limit[i] = 0;
         base[i]  = W'(32'h1000_0000 * (i + 1));
      end
      model_reset();
      wr_count = 0;

      // Reset values
      #12;
      chk("rst_ready", 64'(req_ready), 64'(0));
      chk("rst_wr",    64'(fifo_wr),   64'(0));
      chk("rst_din",   64'(fifo_din),  64'(0));
      chk("rst_level", 64'(level),     64'(0));
      chk("rst_grant", 64'(grant_id),  64'(0));
      chk("rst_busy",  64'(busy),      64'(0));
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // Single requester, three words
      base[0]  = 32'hA0;
      limit[0] = 3;
      wr_count = 0;
      repeat (6) tick(4'b0001, 1'b0);
      chk("single_writes", 64'(wr_count), 64'(3));
      chk("single_level",  64'(level),    64'(3));
      chk("single_idle",   64'(busy),     64'(0));
      repeat (3) tick(4'b0000, 1'b1);

      // Burst cap and credit stall
      limit[1] = 10;
      wr_count = 0;
      repeat (15) tick(4'b0010, 1'b0);
      chk("cap_writes", 64'(wr_count),  64'(8));
      chk("cap_level",  64'(level),     64'(8));
      chk("cap_ready",  64'(req_ready), 64'(0));
      tick(4'b0010, 1'b1);
      tick(4'b0010, 1'b0);
      tick(4'b0010, 1'b0);
      chk("pop_one_write", 64'(wr_count), 64'(9));
      chk("pop_refull",    64'(level),    64'(8));

      // Drain past empty to exercise the underflow guard
      limit[1] = seq[1];
      repeat (11) tick(4'b0000, 1'b1);
      chk("underflow_level", 64'(level), 64'(0));
      limit[3] = seq[3] + 1;
      repeat (3) tick(4'b1000, 1'b0);
      chk("after_guard_level", 64'(level), 64'(1));
      tick(4'b0000, 1'b1);

      // Round-robin with a consumer popping every cycle
      for (int i = 0; i < NR; i++) limit[i] = seq[i] + 1000;
      grants.delete();
      repeat (40) tick(4'b1111, 1'b1);
      chk("rr_grant_count", 64'(grants.size() >= 8), 64'(1));
      for (int k = 0; k < 8 && k < grants.size(); k++) chk("rr_order", 64'(grants[k]), 64'(k % NR));
      for (int i = 0; i < NR; i++) limit[i] = seq[i];
      repeat (10) tick(4'b0000, 1'b1);

      // Reset during the second beat of requester 2
      limit[2] = seq[2] + 5;
      tick(4'b0100, 1'b0);
      tick(4'b0100, 1'b0);
      #2;
      rstn = 1'b0;
      #1;
      chk("mid_rst_busy",  64'(busy),      64'(0));
      chk("mid_rst_ready", 64'(req_ready), 64'(0));
      chk("mid_rst_wr",    64'(fifo_wr),   64'(0));
      chk("mid_rst_level", 64'(level),     64'(0));
      req_valid = '0;
      fifo_rd   = 1'b0;
      model_reset();
      @(posedge clk);
      #3;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      limit[0] = seq[0] + 2;
      grants.delete();
      repeat (4) tick(4'b0101, 1'b0);
      chk("post_rst_first", 64'(grants.size() > 0 ? grants[0] : -1), 64'(0));
      for (int i = 0; i < NR; i++) limit[i] = seq[i];
      repeat (12) tick(4'b0000, 1'b1);

      // Random traffic
      for (int i = 0; i < NR; i++) limit[i] = seq[i] + 100000;
      for (int c = 0; c < 1500; c++) begin
         tick(NR'($urandom), ($urandom % ((c < 750) ? 4 : 2)) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
